// File: rtl/lsu_ctrl.sv
// LSU responder: forwards AGU load/store commands to the data bus and tracks them in an in-order FIFO.
// It aligns and extends load data and retires one response per command. Optional macro: LSU_MISALGN_CHK_EN.
module lsu_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned ITAG_WIDTH = 2,
  parameter int unsigned OTF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agu_cmd_valid,
  output logic                  agu_cmd_ready,
  input  logic [ADDR_SIZE-1:0]  agu_cmd_addr,
  input  logic                  agu_cmd_read,
  input  logic [XLEN-1:0]       agu_cmd_wdata,
  input  logic [1:0]            agu_cmd_size,
  input  logic                  agu_cmd_usign,
  input  logic [ITAG_WIDTH-1:0] agu_cmd_itag,
  output logic                  agu_rsp_valid,
  input  logic                  agu_rsp_ready,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_SIZE-1:0]  mem_cmd_addr,
  output logic                  mem_cmd_read,
  output logic [XLEN-1:0]       mem_cmd_wdata,
  output logic [XLEN/8-1:0]     mem_cmd_wmask,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [XLEN-1:0]       mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  lsu_o_valid,
  input  logic                  lsu_o_ready,
  output logic [XLEN-1:0]       lsu_o_wbck_wdat,
  output logic [ITAG_WIDTH-1:0] lsu_o_itag,
  output logic                  lsu_o_read,
  output logic                  lsu_o_err,
  output logic                  lsu_idle
);

  localparam int unsigned MW = XLEN / 8;
  localparam int unsigned PW = (OTF_DEPTH > 1) ? $clog2(OTF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OTF_DEPTH + 1);

  logic [ITAG_WIDTH-1:0] itag_q  [OTF_DEPTH];
  logic                  read_q  [OTF_DEPTH];
  logic [1:0]            size_q  [OTF_DEPTH];
  logic                  usign_q [OTF_DEPTH];
  logic [1:0]            addr_q  [OTF_DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic          head_mis;
  logic [3:0]    mask4;
  logic [XLEN-1:0] shifted, load_data;

  logic unused_ok;
  assign unused_ok = agu_rsp_ready;

  assign full  = (cnt_q == CW'(OTF_DEPTH));
  assign empty = (cnt_q == '0);

`ifdef LSU_MISALGN_CHK_EN
  logic misalgn_q [OTF_DEPTH];
  logic cmd_mis;

  assign cmd_mis = ((agu_cmd_size == 2'b01) & agu_cmd_addr[0]) |
                   (agu_cmd_size[1] & (agu_cmd_addr[1:0] != 2'b00));
  // Misaligned commands never reach the bus; they retire straight from the FIFO with an error.
  assign mem_cmd_valid = agu_cmd_valid & ~full & ~cmd_mis;
  assign agu_cmd_ready = ~full & (cmd_mis | mem_cmd_ready);
  assign head_mis      = misalgn_q[rptr_q];
  assign lsu_o_valid   = ~empty & (head_mis | mem_rsp_valid);
  assign mem_rsp_ready = lsu_o_ready & ~empty & ~head_mis;

  always_ff @(posedge clk) begin
    if (push) misalgn_q[wptr_q] <= cmd_mis;
  end
`else
  assign mem_cmd_valid = agu_cmd_valid & ~full;
  assign agu_cmd_ready = mem_cmd_ready & ~full;
  assign head_mis      = 1'b0;
  assign lsu_o_valid   = mem_rsp_valid & ~empty;
  assign mem_rsp_ready = lsu_o_ready & ~empty;
`endif

  assign push = agu_cmd_valid & agu_cmd_ready;
  assign pop  = lsu_o_valid & lsu_o_ready;

  assign mem_cmd_addr  = agu_cmd_addr;
  assign mem_cmd_read  = agu_cmd_read;
  assign mem_cmd_wdata = agu_cmd_wdata;

  always_comb begin
    mask4 = 4'b0000;
    if (!agu_cmd_read) begin
      case (agu_cmd_size)
        2'b00:   mask4 = 4'b0001 << agu_cmd_addr[1:0];
        2'b01:   mask4 = agu_cmd_addr[1] ? 4'b1100 : 4'b0011;
        default: mask4 = 4'b1111;
      endcase
    end
  end
  assign mem_cmd_wmask = MW'(mask4);

  always_ff @(posedge clk) begin
    if (push) begin
      itag_q[wptr_q]  <= agu_cmd_itag;
      read_q[wptr_q]  <= agu_cmd_read;
      size_q[wptr_q]  <= agu_cmd_size;
      usign_q[wptr_q] <= agu_cmd_usign;
      addr_q[wptr_q]  <= agu_cmd_addr[1:0];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PW'(OTF_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PW'(OTF_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign shifted = mem_rsp_rdata >> {addr_q[rptr_q], 3'b000};

  always_comb begin
    case (size_q[rptr_q])
      2'b00:   load_data = {{(XLEN-8){~usign_q[rptr_q] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{(XLEN-16){~usign_q[rptr_q] & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign lsu_o_wbck_wdat = (read_q[rptr_q] && !head_mis) ? load_data : '0;
  assign lsu_o_itag      = itag_q[rptr_q];
  assign lsu_o_read      = read_q[rptr_q];
  assign lsu_o_err       = head_mis | mem_rsp_err;
  assign agu_rsp_valid   = pop;
  assign lsu_idle        = empty;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: command pass-through, byte masks, load alignment,
// FIFO full/in-order retirement, reset flush and (when LSU_MISALGN_CHK_EN) misaligned retirement.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [31:0] agu_cmd_addr, agu_cmd_wdata;
  logic [1:0]  agu_cmd_size, agu_cmd_itag;
  logic        agu_rsp_valid, agu_rsp_ready;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_read;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_wmask;
  logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        lsu_o_valid, lsu_o_ready, lsu_o_read, lsu_o_err, lsu_idle;
  logic [31:0] lsu_o_wbck_wdat;
  logic [1:0]  lsu_o_itag;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32), .ADDR_SIZE(32), .ITAG_WIDTH(2), .OTF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .agu_cmd_valid  (agu_cmd_valid),
    .agu_cmd_ready  (agu_cmd_ready),
    .agu_cmd_addr   (agu_cmd_addr),
    .agu_cmd_read   (agu_cmd_read),
    .agu_cmd_wdata  (agu_cmd_wdata),
    .agu_cmd_size   (agu_cmd_size),
    .agu_cmd_usign  (agu_cmd_usign),
    .agu_cmd_itag   (agu_cmd_itag),
    .agu_rsp_valid  (agu_rsp_valid),
    .agu_rsp_ready  (agu_rsp_ready),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd_ready  (mem_cmd_ready),
    .mem_cmd_addr   (mem_cmd_addr),
    .mem_cmd_read   (mem_cmd_read),
    .mem_cmd_wdata  (mem_cmd_wdata),
    .mem_cmd_wmask  (mem_cmd_wmask),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_rdata  (mem_rsp_rdata),
    .mem_rsp_err    (mem_rsp_err),
    .lsu_o_valid    (lsu_o_valid),
    .lsu_o_ready    (lsu_o_ready),
    .lsu_o_wbck_wdat(lsu_o_wbck_wdat),
    .lsu_o_itag     (lsu_o_itag),
    .lsu_o_read     (lsu_o_read),
    .lsu_o_err      (lsu_o_err),
    .lsu_idle       (lsu_idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_cmd(input logic v, input logic [31:0] a, input logic r, input logic [1:0] s,
                         input logic u, input logic [1:0] t, input logic [31:0] wd);
    agu_cmd_valid = v;
    agu_cmd_addr  = a;
    agu_cmd_read  = r;
    agu_cmd_size  = s;
    agu_cmd_usign = u;
    agu_cmd_itag  = t;
    agu_cmd_wdata = wd;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] d, input logic e, input logic rdy);
    mem_rsp_valid = v;
    mem_rsp_rdata = d;
    mem_rsp_err   = e;
    lsu_o_ready   = rdy;
  endtask

  // One full load round trip: issue, then respond and check the aligned/extended result.
  task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                         input logic [31:0] rd, input logic e, input logic [31:0] exp);
    @(negedge clk);
    set_cmd(1'b1, a, 1'b1, s, u, 2'd0, 32'h0);
    #1 check("ld_cmd_valid", mem_cmd_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b1, rd, e, 1'b1);
    #1 check("ld_data", lsu_o_wbck_wdat, exp);
    check("ld_err", lsu_o_err, e);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [1:0]  mk_size [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
  logic [31:0] mk_addr [6] = '{32'h1, 32'h3, 32'h0, 32'h2, 32'h0, 32'h0};
  logic [3:0]  mk_exp  [6] = '{4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b1111};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    agu_rsp_ready = 1'b1;
    mem_cmd_ready = 1'b1;
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_idle", lsu_idle, 1'b1);
    check("rst_o_valid", lsu_o_valid, 1'b0);
    check("rst_agu_rsp", agu_rsp_valid, 1'b0);
    check("rst_cmd_ready", agu_cmd_ready, 1'b1);
    mem_cmd_ready = 1'b0;
    #1 check("cmd_ready_follows_bus", agu_cmd_ready, 1'b0);
    mem_cmd_ready = 1'b1;
    set_rsp(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    #1 check("empty_rsp_ready", mem_rsp_ready, 1'b0);
    check("empty_o_valid", lsu_o_valid, 1'b0);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b0, mk_addr[i], 1'b0, mk_size[i], 1'b0, 2'd0, 32'h0);
      #1 check($sformatf("wmask_%0d", i), mem_cmd_wmask, mk_exp[i]);
    end

    // Load byte, signed, top lane
    @(negedge clk);
    set_cmd(1'b1, 32'h103, 1'b1, 2'd0, 1'b0, 2'd1, 32'h0);
    #1 check("lb_wmask", mem_cmd_wmask, 4'b0000);
    check("lb_cmd_valid", mem_cmd_valid, 1'b1);
    check("lb_cmd_addr", mem_cmd_addr, 32'h103);
    check("lb_cmd_read", mem_cmd_read, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b1, 32'h80FF_1234, 1'b0, 1'b1);
    #1 check("lb_idle", lsu_idle, 1'b0);
    check("lb_o_valid", lsu_o_valid, 1'b1);
    check("lb_data", lsu_o_wbck_wdat, 32'hFFFF_FF80);
    check("lb_read", lsu_o_read, 1'b1);
    check("lb_itag", lsu_o_itag, 2'd1);
    check("lb_err", lsu_o_err, 1'b0);
    check("lb_agu_rsp", agu_rsp_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("lb_agu_rsp_drop", agu_rsp_valid, 1'b0);
    check("lb_idle_after", lsu_idle, 1'b1);

    // Store half, upper lanes
    @(negedge clk);
    set_cmd(1'b1, 32'h202, 1'b0, 2'd1, 1'b0, 2'd2, 32'hBEEF_BEEF);
    #1 check("sh_wmask", mem_cmd_wmask, 4'b1100);
    check("sh_wdata", mem_cmd_wdata, 32'hBEEF_BEEF);
    check("sh_cmd_read", mem_cmd_read, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    #1 check("sh_o_valid", lsu_o_valid, 1'b1);
    check("sh_data", lsu_o_wbck_wdat, 32'h0);
    check("sh_read", lsu_o_read, 1'b0);
    check("sh_itag", lsu_o_itag, 2'd2);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill the FIFO and retire in order, including push and pop in the same cycle
    @(negedge clk);
    set_cmd(1'b1, 32'h0, 1'b1, 2'd2, 1'b0, 2'd1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b1, 32'h4, 1'b1, 2'd2, 1'b0, 2'd2, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b1, 32'h8, 1'b1, 2'd2, 1'b0, 2'd3, 32'h0);
    #1 check("full_cmd_ready", agu_cmd_ready, 1'b0);
    check("full_cmd_valid", mem_cmd_valid, 1'b0);
    set_rsp(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1 check($sformatf("stall_itag_%0d", c), lsu_o_itag, 2'd1);
      check($sformatf("stall_rsp_ready_%0d", c), mem_rsp_ready, 1'b0);
      check($sformatf("stall_o_valid_%0d", c), lsu_o_valid, 1'b1);
      check($sformatf("stall_agu_rsp_%0d", c), agu_rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    set_rsp(1'b1, 32'h1111_1111, 1'b0, 1'b1);
    #1 check("ret1_itag", lsu_o_itag, 2'd1);
    check("ret1_data", lsu_o_wbck_wdat, 32'h1111_1111);
    check("ret1_full_blocks", agu_cmd_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b1, 32'h2222_2222, 1'b0, 1'b1);
    #1 check("ret2_itag", lsu_o_itag, 2'd2);
    check("ret2_data", lsu_o_wbck_wdat, 32'h2222_2222);
    check("tag3_cmd_ready", agu_cmd_ready, 1'b1);
    check("tag3_cmd_valid", mem_cmd_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b1, 32'h3333_3333, 1'b0, 1'b1);
    #1 check("ret3_idle", lsu_idle, 1'b0);
    check("ret3_itag", lsu_o_itag, 2'd3);
    check("ret3_data", lsu_o_wbck_wdat, 32'h3333_3333);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("drain_idle", lsu_idle, 1'b1);

    // Extension cases
    do_load(32'h2, 2'd1, 1'b1, 32'h8001_0000, 1'b1, 32'h0000_8001);
    do_load(32'h0, 2'd1, 1'b0, 32'h1234_8001, 1'b0, 32'hFFFF_8001);
    do_load(32'h1, 2'd0, 1'b1, 32'h0000_F000, 1'b0, 32'h0000_00F0);
    do_load(32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);

`ifdef LSU_MISALGN_CHK_EN
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    set_cmd(1'b1, 32'h101, 1'b1, 2'd2, 1'b0, 2'd2, 32'h0);
    #1 check("mis_cmd_valid", mem_cmd_valid, 1'b0);
    check("mis_cmd_ready", agu_cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    mem_cmd_ready = 1'b1;
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    set_rsp(1'b0, 32'h5555_5555, 1'b0, 1'b1);
    #1 check("mis_o_valid", lsu_o_valid, 1'b1);
    check("mis_err", lsu_o_err, 1'b1);
    check("mis_data", lsu_o_wbck_wdat, 32'h0);
    check("mis_rsp_ready", mem_rsp_ready, 1'b0);
    check("mis_itag", lsu_o_itag, 2'd2);
    @(posedge clk);
    @(negedge clk);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("mis_idle", lsu_idle, 1'b1);
`endif

    // Reset with an entry in flight; late response must be ignored
    @(negedge clk);
    set_cmd(1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 2'd1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_cmd(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
    #1 check("flush_busy", lsu_idle, 1'b0);
    rst = 1'b1;
    #1 check("flush_async_idle", lsu_idle, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_rsp(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);
    #1 check("late_o_valid", lsu_o_valid, 1'b0);
    check("late_rsp_ready", mem_rsp_ready, 1'b0);
    check("late_agu_rsp", agu_rsp_valid, 1'b0);
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
